// File: rtl/hssi_ss_prog_delay_line_if.sv
// Bus bundle for the programmable delay line: streaming beat, delay-load request
// and status outputs, with a master (driver) and slave (delay line) view.
interface hssi_ss_prog_delay_line_if #(
   parameter int WIDTH = 8,
   parameter int DLY_W = 4
);
   logic             en;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             dly_load;
   logic [DLY_W-1:0] dly_in;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [DLY_W-1:0] cur_dly;
   logic             busy;
   logic             dly_clamped;
   logic             drop_err;

   modport master (
      output en, in_valid, in_data, dly_load, dly_in,
      input  out_valid, out_data, cur_dly, busy, dly_clamped, drop_err
   );

   modport slave (
      input  en, in_valid, in_data, dly_load, dly_in,
      output out_valid, out_data, cur_dly, busy, dly_clamped, drop_err
   );
endinterface

// File: rtl/hssi_ss_prog_delay_line.sv
// Stallable, valid-qualified delay line whose depth is reprogrammed at runtime;
// every reprogram flushes in-flight beats and restarts a refill countdown.
module hssi_ss_prog_delay_line #(
   parameter int WIDTH      = 8,
   parameter int MAX_CYCLES = 8,
   parameter int RESET_DLY  = 3,
   parameter int DLY_W      = $clog2(MAX_CYCLES + 1)
) (
   input logic                      clk,
   input logic                      rst_n,
   hssi_ss_prog_delay_line_if.slave bus
);
   localparam logic [DLY_W-1:0] MAX_D   = DLY_W'(MAX_CYCLES);
   localparam logic [DLY_W-1:0] RESET_D = DLY_W'(RESET_DLY);

   logic [MAX_CYCLES:1] stage_v;
   logic [WIDTH-1:0]    stage_d [1:MAX_CYCLES];
   logic [DLY_W-1:0]    cur_dly;
   logic [DLY_W-1:0]    refill_cnt;
   logic [DLY_W-1:0]    load_dly;
   logic                load_clamp;
   logic                clamped_q;
   logic                drop_q;
   logic                tap_v;
   logic [WIDTH-1:0]    tap_d;
   logic                sel_v;
   logic [WIDTH-1:0]    sel_d;
   logic                out_valid;

   assign load_clamp = (bus.dly_in > MAX_D);
   assign load_dly   = load_clamp ? MAX_D : bus.dly_in;

   // A load overrides shifting and applies even while stalled; the payload
   // is left in place because the cleared valid bits already hide it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_v    <= '0;
         for (int k = 1; k <= MAX_CYCLES; k++) begin
            stage_d[k] <= '0;
         end
         cur_dly    <= RESET_D;
         refill_cnt <= RESET_D;
         clamped_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else if (bus.dly_load) begin
         stage_v    <= '0;
         cur_dly    <= load_dly;
         refill_cnt <= load_dly;
         clamped_q  <= load_clamp;
         if (bus.en && bus.in_valid) begin
            drop_q <= 1'b1;
         end
      end else begin
         clamped_q <= 1'b0;
         if (bus.en) begin
            stage_v[1] <= bus.in_valid;
            stage_d[1] <= bus.in_data;
            for (int k = 2; k <= MAX_CYCLES; k++) begin
               stage_v[k] <= stage_v[k-1];
               stage_d[k] <= stage_d[k-1];
            end
            if (refill_cnt != '0) begin
               refill_cnt <= refill_cnt - 1'b1;
            end
         end
      end
   end

   // Tap select: delay 0 bypasses storage entirely, otherwise read stage D.
   always_comb begin
      tap_v = 1'b0;
      tap_d = '0;
      for (int k = 1; k <= MAX_CYCLES; k++) begin
         if (cur_dly == DLY_W'(k)) begin
            tap_v = stage_v[k];
            tap_d = stage_d[k];
         end
      end
      sel_v = (cur_dly == '0) ? bus.in_valid : tap_v;
      sel_d = (cur_dly == '0) ? bus.in_data  : tap_d;
   end

   assign out_valid       = bus.en & sel_v;
   assign bus.out_valid   = out_valid;
   assign bus.out_data    = out_valid ? sel_d : '0;
   assign bus.cur_dly     = cur_dly;
   assign bus.busy        = (refill_cnt != '0);
   assign bus.dly_clamped = clamped_q;
   assign bus.drop_err    = drop_q;
endmodule

// File: tb/tb_hssi_ss_prog_delay_line.sv
// Directed bench for the programmable delay line: reset, streaming, stall,
// delay change, clamp, bypass, back-to-back/stalled loads, drop and mid-stream reset.
module tb_hssi_ss_prog_delay_line;
   localparam int WIDTH      = 8;
   localparam int MAX_CYCLES = 8;
   localparam int RESET_DLY  = 3;
   localparam int DLY_W      = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   hssi_ss_prog_delay_line_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus ();

   hssi_ss_prog_delay_line #(
      .WIDTH(WIDTH),
      .MAX_CYCLES(MAX_CYCLES),
      .RESET_DLY(RESET_DLY)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d,
                                input logic ld, input logic [3:0] dly);
      bus.en       = e;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.dly_load = ld;
      bus.dly_in   = dly;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 4'd0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data} !== 9'h000) begin
         failures++;
         $display("[TB] FAIL reset_out got=%h exp=%h", {bus.out_valid, bus.out_data}, 9'h000);
      end
      checks++;
      if ({bus.cur_dly, bus.busy, bus.dly_clamped, bus.drop_err} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL reset_status got=%h exp=%h",
                  {bus.cur_dly, bus.busy, bus.dly_clamped, bus.drop_err}, {4'd3, 3'b100});
      end
      nextCycle();
   endtask

   task automatic test_reset_stream();
      logic [8:0] expo;
      rst_n = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (c < 16) applyStimulus(1'b1, 1'b1, 8'(c + 1), 1'b0, 4'd0);
         else        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
         @(negedge clk);
         expo = (c >= 3 && c < 19) ? {1'b1, 8'(c - 2)} : 9'h000;
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo) begin
            failures++;
            $display("[TB] FAIL stream_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo);
         end
         checks++;
         if (bus.busy !== (c < 3)) begin
            failures++;
            $display("[TB] FAIL stream_busy c=%0d got=%b exp=%b", c, bus.busy, (c < 3));
         end
         nextCycle();
      end
   endtask

   task automatic test_stall();
      logic [8:0] stall_exp [16];
      int         idx;
      logic       e;
      stall_exp = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h1A0, 9'h000, 9'h000, 9'h1A1,
                    9'h1A2, 9'h1A3, 9'h1A4, 9'h1A5, 9'h1A6, 9'h1A7, 9'h000, 9'h000};
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd4);
      nextCycle();
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         e = !(c == 5 || c == 6);
         if (idx < 8) applyStimulus(e, 1'b1, 8'hA0 + 8'(idx), 1'b0, 4'd0);
         else         applyStimulus(e, 1'b0, 8'h00, 1'b0, 4'd0);
         @(negedge clk);
         checks++;
         if ({bus.out_valid, bus.out_data} !== stall_exp[c]) begin
            failures++;
            $display("[TB] FAIL stall_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, stall_exp[c]);
         end
         checks++;
         if (bus.busy !== (c < 4)) begin
            failures++;
            $display("[TB] FAIL stall_busy c=%0d got=%b exp=%b", c, bus.busy, (c < 4));
         end
         if (e && idx < 8) idx++;
         nextCycle();
      end
   endtask

   task automatic test_delay_change();
      logic [8:0] expo;
      logic       expb;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd3);
      nextCycle();
      for (int c = 0; c < 15; c++) begin
         if (c == 5) applyStimulus(1'b1, 1'b0, 8'(c), 1'b1, 4'd6);
         else        applyStimulus(1'b1, 1'b1, 8'(c), 1'b0, 4'd0);
         @(negedge clk);
         if (c >= 3 && c <= 5) expo = {1'b1, 8'(c - 3)};
         else if (c >= 12)     expo = {1'b1, 8'(c - 6)};
         else                  expo = 9'h000;
         expb = (c < 3) || (c >= 6 && c < 12);
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo) begin
            failures++;
            $display("[TB] FAIL dchg_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo);
         end
         checks++;
         if (bus.busy !== expb) begin
            failures++;
            $display("[TB] FAIL dchg_busy c=%0d got=%b exp=%b", c, bus.busy, expb);
         end
         if (c == 6) begin
            checks++;
            if ({bus.cur_dly, bus.dly_clamped, bus.drop_err} !== {4'd6, 1'b0, 1'b0}) begin
               failures++;
               $display("[TB] FAIL dchg_status got=%h exp=%h",
                        {bus.cur_dly, bus.dly_clamped, bus.drop_err}, {4'd6, 2'b00});
            end
         end
         nextCycle();
      end
   endtask

   task automatic test_clamp();
      logic [8:0] expo;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd13);
      nextCycle();
      for (int c = 0; c < 11; c++) begin
         if (c == 0) applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 4'd0);
         else        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
         @(negedge clk);
         expo = (c == 8) ? 9'h13C : 9'h000;
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo) begin
            failures++;
            $display("[TB] FAIL clamp_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo);
         end
         if (c < 2) begin
            checks++;
            if ({bus.cur_dly, bus.dly_clamped} !== {4'd8, (c == 0)}) begin
               failures++;
               $display("[TB] FAIL clamp_status c=%0d got=%h exp=%h", c,
                        {bus.cur_dly, bus.dly_clamped}, {4'd8, (c == 0)});
            end
         end
         nextCycle();
      end
   endtask

   task automatic test_bypass();
      logic [2:0] vin [4];
      logic [7:0] din [4];
      logic [8:0] expo [4];
      vin  = '{3'b011, 3'b010, 3'b001, 3'b011};
      din  = '{8'h5A, 8'h5A, 8'h5A, 8'hA5};
      expo = '{9'h15A, 9'h000, 9'h000, 9'h1A5};
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd0);
      nextCycle();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(vin[c][1], vin[c][0], din[c], 1'b0, 4'd0);
         @(negedge clk);
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo[c]) begin
            failures++;
            $display("[TB] FAIL bypass_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo[c]);
         end
         checks++;
         if ({bus.cur_dly, bus.busy} !== {4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL bypass_status c=%0d got=%h exp=%h", c, {bus.cur_dly, bus.busy}, 5'h00);
         end
         nextCycle();
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] expo;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd5);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd2);
      nextCycle();
      for (int c = 0; c < 8; c++) begin
         if (c == 0)      applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 4'd0);
         else if (c == 1) applyStimulus(1'b0, 1'b1, 8'h88, 1'b1, 4'd2);
         else if (c == 4) applyStimulus(1'b1, 1'b1, 8'h99, 1'b0, 4'd0);
         else             applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
         @(negedge clk);
         expo = (c == 6) ? 9'h199 : 9'h000;
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo) begin
            failures++;
            $display("[TB] FAIL b2b_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo);
         end
         checks++;
         if (bus.busy !== (c < 4)) begin
            failures++;
            $display("[TB] FAIL b2b_busy c=%0d got=%b exp=%b", c, bus.busy, (c < 4));
         end
         if (c == 0 || c == 2) begin
            checks++;
            if ({bus.cur_dly, bus.drop_err} !== {4'd2, 1'b0}) begin
               failures++;
               $display("[TB] FAIL b2b_status c=%0d got=%h exp=%h", c, {bus.cur_dly, bus.drop_err}, 5'h04);
            end
         end
         nextCycle();
      end
   endtask

   task automatic test_drop_and_reset();
      logic [8:0] expo;
      applyStimulus(1'b1, 1'b1, 8'hDD, 1'b1, 4'd2);
      nextCycle();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, 1'b1, 8'hE0 + 8'(c), 1'b0, 4'd0);
         @(negedge clk);
         expo = (c >= 2) ? {1'b1, 8'hE0 + 8'(c - 2)} : 9'h000;
         checks++;
         if ({bus.out_valid, bus.out_data} !== expo) begin
            failures++;
            $display("[TB] FAIL drop_out c=%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, expo);
         end
         checks++;
         if (bus.drop_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_err c=%0d got=%b exp=1", c, bus.drop_err);
         end
         if (c < 3) nextCycle();
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data} !== 9'h000) begin
         failures++;
         $display("[TB] FAIL midrst_out got=%h exp=%h", {bus.out_valid, bus.out_data}, 9'h000);
      end
      checks++;
      if ({bus.cur_dly, bus.busy, bus.dly_clamped, bus.drop_err} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL midrst_status got=%h exp=%h",
                  {bus.cur_dly, bus.busy, bus.dly_clamped, bus.drop_err}, {4'd3, 3'b100});
      end
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      nextCycle();
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      test_reset();
      test_reset_stream();
      test_stall();
      test_delay_change();
      test_clamp();
      test_bypass();
      test_back_to_back();
      test_drop_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hssi_ss_prog_delay_line.md
# hssi_ss_prog_delay_line

Runtime-programmable, stallable, valid-qualified delay line for the AXI-ST to Avalon-ST bridge datapath. It generalises the fixed per-bit delay register with four additions:
- a per-beat valid bit;
- a clock enable that stalls the whole line;
- a delay selectable at runtime from 0 to MAX_CYCLES, with a flush on every change;
- status reporting for refill, clamping and dropped beats.

Typical use: align sideband (SOP/EOP/error) with data across variable-latency stages.

## Interface
Parameters:
- WIDTH, 8, payload width in bits.
- MAX_CYCLES, 8, deepest delay supported; must be ≥ 1.
- RESET_DLY, 3, delay active after reset; must be ≤ MAX_CYCLES.
- DLY_W, $clog2(MAX_CYCLES+1), width of the delay fields (derived; do not override).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; all storage holds when 0.
- in_valid  in  1  input beat valid.
- in_data  in  WIDTH  input payload.
- dly_load  in  1  single-cycle request to change the delay.
- dly_in  in  DLY_W  requested delay, in en-cycles.
- out_valid  out  1  output beat valid.
- out_data  out  WIDTH  output payload; 0 when out_valid=0.
- cur_dly  out  DLY_W  active delay (registered).
- busy  out  1  high while the line refills after reset or a load.
- dly_clamped  out  1  one-cycle pulse: the last load was clamped.
- drop_err  out  1  sticky: an input beat was discarded by a load.

## Operation
Storage and transfer:
- Storage is stages s[1..MAX_CYCLES], each holding {v, d}.
- A beat is accepted on a rising edge where en=1 and in_valid=1.
- A beat is presented in a cycle where en=1 and the tapped valid is 1.
- All delay is counted in en=1 cycles only.

Shift, when en=1 and dly_load=0:
- s[1] ← {in_valid, in_data}.
- s[k] ← s[k-1] for k ≥ 2.
- Data shifts unconditionally; only the v bits qualify it.
- When en=0, every stage, the refill counter and cur_dly hold.

Output mux, with D = cur_dly:
- D=0: combinational bypass. out_valid = en & in_valid; out_data = in_data when out_valid, else 0.
- D≥1: out_valid = en & s[D].v; out_data = s[D].d when out_valid, else 0.

Delay load:
- dly_load takes effect at the clock edge regardless of en.
- cur_dly ← min(dly_in, MAX_CYCLES).
- Every v bit is cleared, including s[1]. In-flight beats are discarded, never replayed or duplicated.
- If in_valid & en in the load cycle, that beat is dropped and drop_err ← 1. drop_err clears only on reset.
- dly_clamped ← (dly_in > MAX_CYCLES) on the load edge; 0 on every other edge.
- The refill counter loads with the new cur_dly value.
- cur_dly changes on the load edge, so during the load cycle itself the output uses the old D. out_valid may be 1 in the load cycle; that beat counts as delivered.

Refill (busy):
- The counter decrements on each en=1 edge while it is non-zero.
- busy = (counter ≠ 0).
- busy does not gate out_valid, which is already 0 during refill because the stages were invalidated.

Reset values, all asynchronous:
- Every v and d bit: 0.
- cur_dly = RESET_DLY.
- Refill counter = RESET_DLY, so busy=1 if RESET_DLY > 0.
- dly_clamped = 0, drop_err = 0.
- out_valid = 0, out_data = 0.
- Reset asserted mid-stream discards all beats.

## Timing
Latency:
- With cur_dly=D ≥ 1 and en held at 1, a beat accepted at edge N appears on out_valid/out_data in the cycle after edge N+D-1, i.e. D cycles after the cycle it was presented in.
- With D=0, latency is zero.
- Each en=0 cycle adds one cycle to the latency of every beat in flight.

Refill after a load edge L with delay D and continuous en:
- busy is high for D cycles after L.
- The first possible out_valid is the cycle after edge L+D, for a beat accepted at edge L+1.

Simultaneous events:
- dly_load with en=0: the load still applies and the flush still occurs.
- dly_load with dly_in = cur_dly: the line still flushes.
- Back-to-back loads: the last one wins, and the counter restarts.

Throughput: one beat per en cycle, no bubbles at any D.

## Test plan
- Reset then stream: release reset, RESET_DLY=3, send in_data 0x01..0x10 with in_valid=1, en=1 → busy high for 3 cycles; out_valid first high 3 cycles after 0x01 is presented; sequence 0x01..0x10 emerges in order with no gaps.
- Stall: D=4, send 0xA0..0xA7, drop en for 2 cycles mid-stream → output order is unchanged, out_valid=0 during the stall, and total latency of in-flight beats grows by 2.
- Delay change: stream 0x00..0xFF at D=3 and pulse dly_load with dly_in=6 → beats in flight are lost; no output for 6 cycles; then the output resumes with the first beat accepted after the load; dly_clamped=0.
- Clamp: MAX_CYCLES=8, load dly_in=13 → cur_dly=8, dly_clamped pulses for 1 cycle, and measured latency is 8.
- Bypass: load dly_in=0 and drive in_valid/in_data=0x5A → out_valid=1 and out_data=0x5A in the same cycle; busy stays 0.
- Drop and reset: assert in_valid during dly_load → drop_err=1 and remains set; assert rst_n=0 mid-stream → all outputs return to reset values immediately and drop_err=0.
